// File: rtl/aoi_pipe_if.sv
// Handshake and operand/result bundle for aoi_pipe.
// The pipeline itself connects through the slave modport; the producer/consumer side uses master.
interface aoi_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] b1;
  logic [WIDTH-1:0] b2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic [CNT_W-1:0] xfer_cnt;

  modport slave (
    input  in_valid, mode, a1, a2, b1, b2, out_ready,
    output in_ready, out_valid, o, xfer_cnt
  );

  modport master (
    output in_valid, mode, a1, a2, b1, b2, out_ready,
    input  in_ready, out_valid, o, xfer_cnt
  );
endinterface

// File: rtl/aoi_pipe.sv
// Two-stage valid/ready pipeline computing AOI/OAI/AO/OA over WIDTH-bit lanes.
// Define AOI_PIPE_CNT_EN to build the output transfer counter; otherwise xfer_cnt is tied to 0.
module aoi_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  aoi_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_AOI = 2'b00,
    MODE_OAI = 2'b01,
    MODE_AO  = 2'b10,
    MODE_OA  = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
  } operands_t;

  operands_t        s1_q;
  logic             s1_valid;
  logic             init_done;
  logic             out_valid_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] result;
  logic             s2_load;
  logic             in_ready_c;
  logic             in_xfer;
  logic             out_xfer;

  // S2 can take new data when empty or when its current result leaves this cycle.
  assign s2_load    = !out_valid_q || bus.out_ready;
  assign in_ready_c = init_done && (!s1_valid || s2_load);
  assign in_xfer    = bus.in_valid && in_ready_c;
  assign out_xfer   = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.o         = o_q;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    logic [WIDTH-1:0] and_a;
    logic [WIDTH-1:0] and_b;
    logic [WIDTH-1:0] or_a;
    logic [WIDTH-1:0] or_b;
    result = '0;
    and_a  = s1_q.a1 & s1_q.a2;
    and_b  = s1_q.b1 & s1_q.b2;
    or_a   = s1_q.a1 | s1_q.a2;
    or_b   = s1_q.b1 | s1_q.b2;
    unique case (s1_q.mode)
      MODE_AOI: result = ~(and_a | and_b);
      MODE_OAI: result = ~(or_a & or_b);
      MODE_AO:  result = and_a | and_b;
      MODE_OA:  result = or_a & or_b;
      default:  result = '0;
    endcase
  end

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      // NOTE: operand registers are cleared too, so o and S1 are fully defined right after reset.
      s1_q     <= operands_t'('0);
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_q     <= '{mode: mode_e'(bus.mode), a1: bus.a1, a2: bus.a2,
                      b1: bus.b1, b2: bus.b2};
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      o_q         <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        o_q <= result;
      end
    end
  end

`ifdef AOI_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.xfer_cnt = cnt_q;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
  assign bus.xfer_cnt    = '0;
`endif

endmodule

// File: tb/tb_aoi_pipe.sv
// Directed bench for aoi_pipe: vector table, backpressure, mid-operation reset and 256-deep streaming.
// Counter expectations follow whether AOI_PIPE_CNT_EN is defined for the build.
module tb_aoi_pipe;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [3:0] b1;
    logic [3:0] b2;
    logic [3:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_xfers;

  aoi_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  aoi_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.mode     = v.mode;
    bus.a1       = v.a1;
    bus.a2       = v.a2;
    bus.b1       = v.b1;
    bus.b2       = v.b2;
  endtask

  function automatic logic [7:0] exp_cnt();
`ifdef AOI_PIPE_CNT_EN
    return 8'(exp_xfers);
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic [3:0] model(input logic [1:0] m, input logic [3:0] a1,
                                       input logic [3:0] a2, input logic [3:0] b1,
                                       input logic [3:0] b2);
    case (m)
      2'b00:   return ~((a1 & a2) | (b1 & b2));
      2'b01:   return ~((a1 | a2) & (b1 | b2));
      2'b10:   return (a1 & a2) | (b1 & b2);
      default: return (a1 | a2) & (b1 | b2);
    endcase
  endfunction

  initial begin
    vec_t       vecs[9];
    logic [3:0] q[$];
    logic [7:0] sv;
    logic [3:0] e;

    vecs[0] = '{2'b00, 4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b0111};
    vecs[1] = '{2'b01, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 4'b1000};
    vecs[2] = '{2'b11, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 4'b0111};
    vecs[3] = '{2'b10, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 4'b0001};
    vecs[4] = '{2'b00, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 4'b1110};
    vecs[5] = '{2'b00, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[6] = '{2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[7] = '{2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vecs[8] = '{2'b10, 4'b1010, 4'b1110, 4'b0101, 4'b0111, 4'b1111};

    n_checks      = 0;
    n_fail        = 0;
    exp_xfers     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.a1        = '0;
    bus.a2        = '0;
    bus.b1        = '0;
    bus.b2        = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_o", bus.o, 0);
    check("rst_xfer_cnt", bus.xfer_cnt, 0);
    check("rst_in_ready", bus.in_ready, 0);
    #10;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", bus.in_ready, 0);
    tick();
    check("in_ready_after_first_edge", bus.in_ready, 1);

    // Table: one operand set at a time, two-cycle latency, then drain
    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_not_early", i), bus.out_valid, 0);
      tick();
      check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d_o", i), bus.o, vecs[i].exp);
      exp_xfers++;
      tick();
      check($sformatf("vec%0d_drained", i), bus.out_valid, 0);
    end
    check("cnt_after_table", bus.xfer_cnt, exp_cnt());

    // Backpressure: three offered, two accepted, o held, drain in order
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    check("bp_accept_a", bus.in_ready, 1);
    tick();
    drive(vecs[1]);
    check("bp_accept_b", bus.in_ready, 1);
    tick();
    drive(vecs[2]);
    check("bp_full_in_ready", bus.in_ready, 0);
    check("bp_o_first", bus.o, vecs[0].exp);
    tick();
    check("bp_still_full", bus.in_ready, 0);
    check("bp_o_stable", bus.o, vecs[0].exp);
    check("bp_valid_held", bus.out_valid, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_o_a", bus.o, vecs[0].exp);
    tick();
    exp_xfers++;
    check("bp_valid_b", bus.out_valid, 1);
    check("bp_o_b", bus.o, vecs[1].exp);
    tick();
    exp_xfers++;
    check("bp_empty", bus.out_valid, 0);
    check("cnt_after_bp", bus.xfer_cnt, exp_cnt());

    // Reset with two results in flight clears outputs without a clock edge
    bus.out_ready = 1'b0;
    drive(vecs[3]);
    tick();
    drive(vecs[8]);
    tick();
    bus.in_valid = 1'b0;
    check("mid_two_in_flight", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_o", bus.o, 0);
    check("mid_rst_xfer_cnt", bus.xfer_cnt, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    #2;
    rst_n         = 1'b1;
    exp_xfers     = 0;
    bus.out_ready = 1'b1;
    tick();
    check("mid_in_ready_back", bus.in_ready, 1);
    check("mid_no_partial_1", bus.out_valid, 0);
    tick();
    check("mid_no_partial_2", bus.out_valid, 0);
    check("mid_cnt_zero", bus.xfer_cnt, 0);

    // Streaming: 256 back-to-back, one result per cycle, counter wraps to 0
    for (int step = 0; step < 258; step++) begin
      if (step < 256) begin
        sv           = 8'(step);
        bus.in_valid = 1'b1;
        bus.mode     = sv[1:0];
        bus.a1       = sv[3:0];
        bus.a2       = sv[7:4];
        bus.b1       = ~sv[3:0];
        bus.b2       = sv[5:2];
        check($sformatf("st%0d_in_ready", step), bus.in_ready, 1);
        q.push_back(model(sv[1:0], sv[3:0], sv[7:4], ~sv[3:0], sv[5:2]));
      end else begin
        bus.in_valid = 1'b0;
      end
      if (step >= 2) begin
        e = q.pop_front();
        check($sformatf("st%0d_out_valid", step), bus.out_valid, 1);
        check($sformatf("st%0d_o", step), bus.o, e);
        if (step == 257) begin
          check("st_cnt_before_last", bus.xfer_cnt, exp_cnt());
        end
        exp_xfers++;
      end
      tick();
    end
    check("st_drained", bus.out_valid, 0);
    check("st_cnt_wrapped", bus.xfer_cnt, exp_cnt());
    check("st_cnt_zero", bus.xfer_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aoi_pipe.md
AOI_PIPE -- requirements
Module: aoi_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of each operand and the result (bitwise per lane).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the transfer counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have port mode, input, 2 bits: function select, sampled with the operands.
REQ-008 The block SHALL have ports a1, a2, b1 and b2, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: o holds a valid result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream sink accepts o.
REQ-011 The block SHALL have port o, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port xfer_cnt, output, CNT_W bits: the count of completed output transfers.

Function
REQ-013 A transfer in SHALL occur when in_valid and in_ready are both 1 at a rising edge; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-014 mode SHALL select the function as follows: 00 = ~((a1&a2)|(b1&b2)) (AOI); 01 = ~((a1|a2)&(b1|b2)) (OAI); 10 = (a1&a2)|(b1&b2) (AO); 11 = (a1|a2)&(b1|b2) (OA). All functions are bitwise over WIDTH.
REQ-015 The pipeline SHALL have two register stages: S1 registers the operands and mode, and S2 registers the computed result into o.
REQ-016 Latency SHALL be 2 cycles from a transfer in to out_valid=1 when the pipeline is not stalled.
REQ-017 Throughput SHALL be one result per cycle while out_ready=1.
REQ-018 S2 SHALL load when S2 is empty or an output transfer occurs in the same cycle.
REQ-019 S1 SHALL advance into S2 under the REQ-018 condition; an empty S1 SHALL be filled whenever possible (bubble collapse).
REQ-020 in_ready SHALL equal (!s1_valid) | s2_load, where s2_load is the REQ-018 condition; a combinational path from out_ready to in_ready is permitted.
REQ-021 When out_valid=1 and out_ready=0, o SHALL be held stable and no data SHALL be lost or reordered; at most 2 results are in flight.
REQ-022 A simultaneous transfer in and transfer out with both stages full SHALL sustain full throughput with no bubble.
REQ-023 When in_valid=0, nothing SHALL be accepted and no stage contents SHALL change except by draining.
REQ-024 xfer_cnt SHALL increment by 1 on each transfer out and wrap from 2^CNT_W-1 to 0 without saturation.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously clear s1_valid and out_valid to 0, clear o to 0, clear the S1 data registers to 0, and clear xfer_cnt to 0.
REQ-026 While rst_n=0, in_ready SHALL be 0.
REQ-027 in_ready SHALL be 1 from the first rising edge after rst_n is released.
REQ-028 A reset asserted mid-operation SHALL discard in-flight results, with no partial transfer afterward.

Configuration
REQ-029 With macro AOI_PIPE_CNT_EN defined, the transfer counter SHALL be implemented as in REQ-024.
REQ-030 With AOI_PIPE_CNT_EN undefined, xfer_cnt SHALL be tied to constant 0 with no counter registers, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset scenario: assert rst_n=0 while 2 results are in flight -> out_valid=0, o=0 and xfer_cnt=0 immediately, without waiting for a clock edge.
REQ-032 AOI scenario: WIDTH=4, mode=00, a1=1100, a2=1010, b1=0000, b2=0000, out_ready=1 -> o=0111 with out_valid=1 exactly 2 cycles after acceptance.
REQ-033 All-modes scenario: a1=0011, a2=0101, b1=1111, b2=0000 -> mode 01 gives o=1000, mode 11 gives o=0111, and mode 10 gives o=0001 (a1&a2=0001, b1&b2=0000).
REQ-034 Backpressure scenario: out_ready=0 and in_valid=1 for 3 cycles -> 2 operand sets accepted, then in_ready=0; o is stable; after out_ready=1, results emerge in order with none dropped.
REQ-035 Streaming and counter scenario: AOI_PIPE_CNT_EN defined, CNT_W=8, 256 back-to-back transfers with out_ready=1 -> one result per cycle and xfer_cnt returns to 0 after the 256th transfer out.
REQ-036 Counter-disabled scenario: AOI_PIPE_CNT_EN undefined, repeat REQ-035 -> xfer_cnt remains 0 throughout and results are identical.
